// File: rtl/counter_sched_if.sv
// Command/response and counter-control bundle between requesters, counter_sched and the counter.
// master is the environment side (requesters plus counter), slave is the scheduler.
interface counter_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_arg;
  logic [NUM_REQ-1:0]       done;
  logic [WIDTH-1:0]         result;
  logic [WIDTH-1:0]         cnt_data_in;
  logic                     cnt_ld;
  logic                     cnt_inc;
  logic [WIDTH-1:0]         cnt_q;

  modport master (
    output req_valid, req_op, req_arg, cnt_q,
    input  req_ready, done, result, cnt_data_in, cnt_ld, cnt_inc
  );

  modport slave (
    input  req_valid, req_op, req_arg, cnt_q,
    output req_ready, done, result, cnt_data_in, cnt_ld, cnt_inc
  );
endinterface

// File: rtl/counter_sched.sv
// Round-robin scheduler running LOAD / INC_N / RUN_TO / NOP commands on a shared load/inc
// counter, one command at a time, returning the final count with a per-owner done pulse.
module counter_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  counter_sched_if.slave bus,
  output logic           busy_o
);
  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OpLoad = 2'd0;
  localparam logic [1:0] OpInc  = 2'd1;
  localparam logic [1:0] OpRun  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [PtrW-1:0]  owner_q, owner_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             ld_q, ld_d;
  logic             inc_q, inc_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic               grant_found;
  logic [PtrW-1:0]    grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [1:0]         sel_op;
  logic [WIDTH-1:0]   sel_arg;
  logic [WIDTH-1:0]   cnt_next;
  logic [NUM_REQ-1:0] owner_oh;

  // Search starts one past the last winner so every valid requester is reached within NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      if (!grant_found && bus.req_valid[(int'(ptr_q) + i) % int'(NUM_REQ)]) begin
        grant_found = 1'b1;
        grant_idx   = PtrW'((int'(ptr_q) + i) % int'(NUM_REQ));
      end
    end
  end

  assign grant_oh = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;
  assign sel_op   = bus.req_op[2*int'(grant_idx) +: 2];
  assign sel_arg  = bus.req_arg[WIDTH*int'(grant_idx) +: WIDTH];

  // Value the counter will hold after this cycle, since cnt_inc is already registered.
  assign cnt_next = bus.cnt_q + {{(WIDTH-1){1'b0}}, inc_q};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    op_d    = op_q;
    arg_d   = arg_q;
    rem_d   = rem_q;
    ld_d    = 1'b0;
    inc_d   = 1'b0;
    data_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d = EXEC;
          ptr_d   = grant_idx;
          owner_d = grant_idx;
          op_d    = sel_op;
          arg_d   = sel_arg;
          rem_d   = sel_arg - WIDTH'(1);
          if (sel_op == OpLoad) begin
            ld_d   = 1'b1;
            data_d = sel_arg;
          end
          if (sel_op == OpInc && sel_arg != '0) inc_d = 1'b1;
        end
      end
      EXEC: begin
        unique case (op_q)
          OpInc: begin
            if (inc_q && rem_q != '0) begin
              inc_d = 1'b1;
              rem_d = rem_q - WIDTH'(1);
            end else begin
              state_d = DONE;
            end
          end
          OpRun: begin
            if (cnt_next == arg_q) state_d = DONE;
            else                   inc_d   = 1'b1;
          end
          default: state_d = DONE;
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= PtrW'(NUM_REQ - 1);
      owner_q <= '0;
      op_q    <= '0;
      arg_q   <= '0;
      rem_q   <= '0;
      ld_q    <= 1'b0;
      inc_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      rem_q   <= rem_d;
      ld_q    <= ld_d;
      inc_q   <= inc_d;
      data_q  <= data_d;
    end
  end

  assign owner_oh = NUM_REQ'(1) << owner_q;

  // Ready is gated by reset so nothing looks accepted while the block is held in reset.
  assign bus.req_ready   = (rst_ni && state_q == IDLE) ? grant_oh : '0;
  assign bus.done        = (state_q == DONE) ? owner_oh : '0;
  assign bus.result      = (state_q == DONE) ? bus.cnt_q : '0;
  assign bus.cnt_ld      = ld_q;
  assign bus.cnt_inc     = inc_q;
  assign bus.cnt_data_in = data_q;
  assign busy_o          = (state_q != IDLE);
endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
Round-robin command scheduler that shares one 8-bit load/increment counter between several requesters. Each requester issues LOAD, INC_N or RUN_TO commands over a valid/ready handshake. The scheduler runs one command at a time by sequencing the counter's ld/inc/data_in inputs, then returns the final count with a per-requester done pulse. It sits between the requesting agents and the counter datapath; the counter shares the same clk/rst.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, counter data width (matches counter data_in/q)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-low
req_valid  input  NUM_REQ  per-requester command valid
req_ready  output  NUM_REQ  per-requester accept; at most one bit high
req_op  input  2*NUM_REQ  packed op, requester i at [2i+1:2i]: 00 LOAD, 01 INC_N, 10 RUN_TO, 11 NOP
req_arg  input  WIDTH*NUM_REQ  packed argument, requester i at [WIDTH*i +: WIDTH]
done  output  NUM_REQ  one-cycle completion pulse to the owning requester
result  output  WIDTH  counter value at completion, valid while done is nonzero
busy  output  1  high whenever state is not IDLE
cnt_data_in  output  WIDTH  counter load data
cnt_ld  output  1  counter load enable
cnt_inc  output  1  counter increment enable
cnt_q  input  WIDTH  counter output

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low. While rst=0: state=IDLE; rr pointer=NUM_REQ-1, so requester 0 wins first; req_ready, done, result, cnt_data_in, cnt_ld, cnt_inc and busy all 0.
- Counter contract: on posedge, ld loads data_in; otherwise inc adds 1 mod 2^WIDTH. The scheduler never drives cnt_ld and cnt_inc high together.
- FSM states: IDLE, EXEC, DONE.
- IDLE arbitration:
  - Search req_valid starting at pointer+1 mod NUM_REQ; the first set bit g wins.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - Acceptance is req_valid[g]&req_ready[g]. On acceptance: capture op and arg, set owner=g, pointer=g, go to EXEC.
  - req_ready is 0 in every state except IDLE.
  - A requester may drop valid before acceptance with no effect. Op and arg are sampled only at acceptance.
- EXEC, LOAD: one cycle with cnt_ld=1 and cnt_data_in=arg, then DONE.
- EXEC, INC_N (N=arg):
  - N=0: one EXEC cycle with no inc, then DONE.
  - N>0: cnt_inc=1 for exactly N consecutive cycles, then DONE. The counter wraps mod 2^WIDTH.
- EXEC, RUN_TO:
  - Each EXEC cycle compares cnt_q with arg.
  - Not equal: cnt_inc=1 and stay in EXEC.
  - Equal: cnt_inc=0 and go to DONE.
  - Wraps through 2^WIDTH-1 to 0. At most 2^WIDTH-1 increments.
- EXEC, NOP: one EXEC cycle with no counter activity, then DONE.
- Outputs outside active cycles: cnt_ld, cnt_inc and cnt_data_in are 0 outside the EXEC cycles that drive them. All three are registered (Moore), with no combinational path from req_* to cnt_*.
- DONE: lasts one cycle. done[owner]=1 and result=cnt_q (includes the final counter update). Next state is IDLE; done and result return to 0.
- Latency, with acceptance in cycle T:
  - LOAD and NOP: DONE at T+2. LOAD gives result=arg.
  - INC_N, N>0: inc in T+1..T+N, DONE at T+N+1.
  - INC_N, N=0: DONE at T+2.
  - RUN_TO needing k increments: DONE at T+k+2.
- Back-to-back: the earliest next acceptance is the IDLE cycle after DONE. A requester whose valid is high in DONE is eligible then. Fairness: a continuously requesting agent waits at most NUM_REQ-1 other commands.
- Reset mid-operation: all state clears immediately. The in-flight command is dropped with no done pulse. The counter is also reset by rst.
- Assertions the bench carries:
  - onehot0(req_ready) and onehot0(done).
  - !(cnt_ld&&cnt_inc).
  - busy==(state!=IDLE).

Test Plan:
- LOAD: req0 LOAD arg=8'h5A -> req_ready[0] in acceptance cycle T, cnt_ld=1 with cnt_data_in=8'h5A at T+1, done[0] with result=8'h5A at T+2.
- INC_N with wrap: counter preloaded 8'hFE, req1 INC_N arg=3 -> cnt_inc high exactly 3 cycles, done[1] with result=8'h01. INC_N arg=0 -> no inc, result unchanged, done at T+2.
- RUN_TO with wrap: counter at 8'hF0, req2 RUN_TO arg=8'h05 -> exactly 21 inc cycles, done[2] at T+23, result=8'h05. RUN_TO arg equal to current q -> zero incs, done at T+2.
- Round-robin: all 4 requesters hold valid with NOP from reset -> grant order 0,1,2,3,0; each done pulse goes only to its owner. Holding only req3 high -> it is served every command slot.
- Reset mid-operation: assert rst low during the 5th cycle of INC_N arg=100 -> all outputs 0 immediately, no done pulse, pointer returns so requester 0 wins the next arbitration.
- Simultaneous events: req0 raises valid in the DONE cycle of req1's command -> req0 is accepted in the following IDLE cycle. req_ready is never high outside IDLE.
